pll_reconfig_ctrl: RTL and testbench

- Avalon-MM master that drives the Cyclone V PLL reconfiguration slave sitting on the system PLL's reconfig_to_pll/reconfig_from_pll buses.
- Switches the PLL VCO between the NTSC master-clock setting (VCO 429.5454 MHz) and the PAL setting (VCO 425.6274 MHz) by rewriting the M counter and fractional K, then waits for relock.
- Sits beside the PLL in the top level. cfg_sel comes from the video-standard select; busy gates core reset while the clock is unstable.

---
 rtl/pll_reconfig_ctrl_if.sv | 15 +
 rtl/pll_reconfig_ctrl.sv | 144 ++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reconfig_ctrl_if.sv
// Avalon-MM management bus between the PLL reconfig controller and the
// PLL reconfiguration slave.
interface pll_reconfig_ctrl_if;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0] address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic              waitrequest;

  modport master (output address, write, writedata, read, input waitrequest);
  modport slave  (input address, write, writedata, read, output waitrequest);
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// Rewrites the PLL M counter and fractional K to switch the VCO between the
// NTSC and PAL master-clock settings, then waits for relock.
module pll_reconfig_ctrl #(
  parameter logic [31:0] M_CNT        = 32'h0000_0404,
  parameter logic [31:0] K_NTSC       = 32'd2537930535,
  parameter logic [31:0] K_PAL        = 32'd2201376898,
  parameter logic [19:0] LOCK_TIMEOUT = 20'hFFFFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_sel,
  input  logic                       pll_locked,
  pll_reconfig_ctrl_if.master        mgmt,
  output logic                       busy,
  output logic                       cfg_cur,
  output logic                       err
);

  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned TMR_W      = 20;
  localparam int unsigned MIN_LOCK_T = 4;

  localparam logic [ADDR_W-1:0] ADDR_MODE  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_START = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_M     = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_K     = ADDR_W'(7);

  typedef enum logic [3:0] {
    IDLE, WR_MODE, WR_M, WR_K, WR_START, WAIT_REC, WAIT_LOCK, DONE, ERR
  } state_t;

  state_t             state;
  state_t             wr_next;
  logic               tgt;
  logic [TMR_W-1:0]   timer;
  logic               locked_meta;
  logic               locked_sync;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;

  assign mgmt.read = 1'b0;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_meta <= 1'b0;
      locked_sync <= 1'b0;
    end else begin
      locked_meta <= pll_locked;
      locked_sync <= locked_meta;
    end
  end

  // Register address/data and successor for each write state
  always_comb begin
    wr_addr = ADDR_MODE;
    wr_data = '0;
    wr_next = WR_M;
    case (state)
      WR_M: begin
        wr_addr = ADDR_M;
        wr_data = M_CNT;
        wr_next = WR_K;
      end
      WR_K: begin
        wr_addr = ADDR_K;
        wr_data = tgt ? K_PAL : K_NTSC;
        wr_next = WR_START;
      end
      WR_START: begin
        wr_addr = ADDR_START;
        wr_data = DATA_W'(1);
        wr_next = WAIT_REC;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      tgt            <= 1'b0;
      timer          <= '0;
      mgmt.write     <= 1'b0;
      mgmt.address   <= '0;
      mgmt.writedata <= '0;
      busy           <= 1'b0;
      cfg_cur        <= 1'b0;
      err            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_sel != cfg_cur) begin
            tgt   <= cfg_sel;
            busy  <= 1'b1;
            err   <= 1'b0;
            state <= WR_MODE;
          end
        end
        // Write is raised one cycle after entry, so consecutive writes are
        // separated by one idle cycle.
        WR_MODE, WR_M, WR_K, WR_START: begin
          if (!mgmt.write) begin
            mgmt.write     <= 1'b1;
            mgmt.address   <= wr_addr;
            mgmt.writedata <= wr_data;
          end else if (!mgmt.waitrequest) begin
            mgmt.write <= 1'b0;
            state      <= wr_next;
          end
        end
        WAIT_REC: begin
          if (!mgmt.waitrequest) begin
            timer <= '0;
            state <= WAIT_LOCK;
          end
        end
        // A stale lock from before the reconfig is ignored for the first cycles
        WAIT_LOCK: begin
          if (locked_sync && (timer >= TMR_W'(MIN_LOCK_T))) begin
            state <= DONE;
          end else if (timer == LOCK_TIMEOUT) begin
            state <= ERR;
          end else if (timer != '1) begin
            timer <= timer + TMR_W'(1);
          end
        end
        DONE: begin
          cfg_cur <= tgt;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        ERR: begin
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl: Avalon slave/PLL model plus a linear
// sequence of standard switches with hand-computed expectations.
module tb_pll_reconfig_ctrl;

  localparam logic [31:0] M_CNT  = 32'h0000_0404;
  localparam logic [31:0] K_NTSC = 32'd2537930535;
  localparam logic [31:0] K_PAL  = 32'd2201376898;
  localparam logic [19:0] TMO    = 20'd100;
  localparam int          BUDGET = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_sel = 1'b0;
  logic pll_locked = 1'b0;
  logic busy, cfg_cur, err;

  pll_reconfig_ctrl_if mgmt();

  pll_reconfig_ctrl #(
    .M_CNT(M_CNT), .K_NTSC(K_NTSC), .K_PAL(K_PAL), .LOCK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_sel(cfg_sel), .pll_locked(pll_locked),
    .mgmt(mgmt), .busy(busy), .cfg_cur(cfg_cur), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave/PLL model configuration (written by the stimulus only)
  logic drop_en    = 1'b0;
  logic lock_en    = 1'b1;
  int   lock_delay = 50;
  int   k_stall    = 0;
  int   rec_stall  = 0;

  // Slave/PLL model state (written by the model only)
  int          rec_left = 0, k_left = 0, lock_left = 0;
  int          stall_cnt = 0, stab_err = 0;
  logic        wreq = 1'b0;
  logic        prev_stall = 1'b0;
  logic [5:0]  prev_addr = '0;
  logic [31:0] prev_data = '0;
  logic [5:0]  log_addr[$];
  logic [31:0] log_data[$];

  // Decides waitrequest for the coming edge and logs writes that will be accepted
  always @(negedge clk) begin
    if (!rst_n) begin
      mgmt.waitrequest = 1'b0;
      rec_left   = 0;
      k_left     = 0;
      lock_left  = 0;
      prev_stall = 1'b0;
      pll_locked = lock_en;
    end else begin
      if (prev_stall && !(mgmt.write === 1'b1 && mgmt.address === prev_addr &&
                          mgmt.writedata === prev_data))
        stab_err++;
      if (rec_left > 0) begin
        wreq = 1'b1;
        rec_left--;
      end else if (mgmt.write === 1'b1 && mgmt.address === 6'd7 && k_left > 0) begin
        wreq = 1'b1;
        k_left--;
      end else begin
        wreq = 1'b0;
      end
      mgmt.waitrequest = wreq;
      if (wreq) stall_cnt++;
      prev_stall = (mgmt.write === 1'b1) && wreq;
      prev_addr  = mgmt.address;
      prev_data  = mgmt.writedata;
      if (mgmt.write === 1'b1 && !wreq) begin
        log_addr.push_back(mgmt.address);
        log_data.push_back(mgmt.writedata);
        if (mgmt.address === 6'd4) k_left = k_stall;
        if (mgmt.address === 6'd2) begin
          rec_left = rec_stall;
          if (drop_en) lock_left = lock_delay;
        end
      end else if (lock_left > 0) begin
        lock_left--;
      end
      pll_locked = (lock_left == 0) && lock_en;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for busy to rise (if not already high) and then fall; cyc = cycles high
  task automatic wait_busy_fall(input string tag, output int cyc);
    int b = 0;
    cyc = 0;
    while (busy !== 1'b1 && b < BUDGET) begin
      tick();
      b++;
    end
    check({tag, " busy_rise"}, 32'(busy), 32'd1);
    while (busy === 1'b1 && cyc < BUDGET) begin
      cyc++;
      tick();
    end
    check({tag, " busy_fall"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_log(input string tag, input int n);
    int b = 0;
    while (log_addr.size() < n && b < BUDGET) begin
      tick();
      b++;
    end
    check({tag, " log_count"}, 32'(log_addr.size()), 32'(n));
  endtask

  // Checks one complete four-write sequence starting at log index base
  task automatic check_seq(input string tag, input int base, input logic [31:0] k);
    logic [5:0]  ea[4];
    logic [31:0] ed[4];
    ea = '{6'd0, 6'd4, 6'd7, 6'd2};
    ed = '{32'd0, M_CNT, k, 32'd1};
    check({tag, " nwrites"}, 32'(log_addr.size() - base), 32'd4);
    if (log_addr.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s addr%0d", tag, i), 32'(log_addr[base+i]), 32'(ea[i]));
        check($sformatf("%s data%0d", tag, i), log_data[base+i], ed[i]);
      end
    end
  endtask

  initial begin
    int cyc, base, st0, se0;

    // Reset, then idle with NTSC selected and PLL locked
    cfg_sel = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (100) tick();
    check("t1 busy", 32'(busy), 32'd0);
    check("t1 cfg_cur", 32'(cfg_cur), 32'd0);
    check("t1 err", 32'(err), 32'd0);
    check("t1 write", 32'(mgmt.write), 32'd0);
    check("t1 read", 32'(mgmt.read), 32'd0);
    check("t1 nwrites", 32'(log_addr.size()), 32'd0);

    // NTSC -> PAL, lock drops and returns 50 cycles after START
    drop_en = 1'b1;
    lock_delay = 50;
    base = log_addr.size();
    se0 = stab_err;
    cfg_sel = 1'b1;
    wait_busy_fall("t2", cyc);
    check_seq("t2", base, K_PAL);
    check("t2 cfg_cur", 32'(cfg_cur), 32'd1);
    check("t2 err", 32'(err), 32'd0);
    check("t2 stable", 32'(stab_err - se0), 32'd0);

    // PAL -> NTSC with 5 stall cycles on K and 30 after START
    k_stall = 5;
    rec_stall = 30;
    base = log_addr.size();
    st0 = stall_cnt;
    se0 = stab_err;
    cfg_sel = 1'b0;
    wait_busy_fall("t3", cyc);
    check_seq("t3", base, K_NTSC);
    check("t3 stalls", 32'(stall_cnt - st0), 32'd35);
    check("t3 stable", 32'(stab_err - se0), 32'd0);
    check("t3 cfg_cur", 32'(cfg_cur), 32'd0);
    k_stall = 0;
    rec_stall = 0;

    // Lock never drops: stale lock masked until timer reaches 4 -> 15 busy cycles
    drop_en = 1'b0;
    base = log_addr.size();
    cfg_sel = 1'b1;
    wait_busy_fall("t7", cyc);
    check("t7 busy_cycles", 32'(cyc), 32'd15);
    check_seq("t7", base, K_PAL);
    check("t7 cfg_cur", 32'(cfg_cur), 32'd1);

    // PAL -> NTSC with no lock: timeout at timer=100, then automatic retry
    lock_en = 1'b0;
    tick();
    base = log_addr.size();
    cfg_sel = 1'b0;
    wait_busy_fall("t4", cyc);
    check("t4 busy_cycles", 32'(cyc), 32'd111);
    check("t4 err", 32'(err), 32'd1);
    check("t4 cfg_cur", 32'(cfg_cur), 32'd1);
    check_seq("t4", base, K_NTSC);
    tick();
    check("t4 retry busy", 32'(busy), 32'd1);
    check("t4 retry err", 32'(err), 32'd0);
    base = log_addr.size();
    wait_log("t4 retry", base + 3);
    check("t4 retry k_addr", 32'(log_addr[base+2]), 32'd7);
    check("t4 retry k_data", log_data[base+2], K_NTSC);
    lock_en = 1'b1;
    wait_busy_fall("t4 retry", cyc);
    check("t4 retry cfg_cur", 32'(cfg_cur), 32'd0);
    check("t4 retry err_end", 32'(err), 32'd0);

    // NTSC -> PAL -> NTSC with the revert during WAIT_LOCK
    drop_en = 1'b1;
    base = log_addr.size();
    cfg_sel = 1'b1;
    wait_log("t6", base + 4);
    repeat (5) tick();
    cfg_sel = 1'b0;
    wait_busy_fall("t6 first", cyc);
    check_seq("t6 first", base, K_PAL);
    check("t6 first cfg_cur", 32'(cfg_cur), 32'd1);
    base = log_addr.size();
    wait_busy_fall("t6 second", cyc);
    check_seq("t6 second", base, K_NTSC);
    check("t6 second cfg_cur", 32'(cfg_cur), 32'd0);

    // Reset during WR_K: write drops immediately, sequence restarts from WR_MODE
    cfg_sel = 1'b1;
    cyc = 0;
    while (!(mgmt.write === 1'b1 && mgmt.address === 6'd7) && cyc < BUDGET) begin
      tick();
      cyc++;
    end
    check("t5 reach_wr_k", 32'(mgmt.address), 32'd7);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5 write_async", 32'(mgmt.write), 32'd0);
    check("t5 busy_rst", 32'(busy), 32'd0);
    check("t5 cfg_cur_rst", 32'(cfg_cur), 32'd0);
    repeat (3) tick();
    base = log_addr.size();
    rst_n = 1'b1;
    wait_busy_fall("t5", cyc);
    check_seq("t5", base, K_PAL);
    check("t5 cfg_cur", 32'(cfg_cur), 32'd1);
    check("t5 err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
